// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types and L2 tag-path constants/helpers
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [8:0]  lc3b_l2tag;
    typedef logic [2:0]  lc3b_plru;

    localparam int L2_WAYS  = 4;
    localparam int L2_SETS  = 8;
    localparam int L2_TAG_W = 9;
    localparam int L2_SET_W = 3;
    localparam int L2_OFF_W = 4;

    typedef enum logic [1:0] {
        L2_IDLE,
        L2_LOOKUP,
        L2_RESP
    } l2_state_e;

    // Mark a way most-recently-used: point the tree bits away from it.
    function automatic lc3b_plru plru_touch(input lc3b_plru p, input logic [1:0] way);
        lc3b_plru n;
        n = p;
        case (way)
            2'd0: begin n[2] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[2] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[2] = 1'b0; n[0] = 1'b1; end
            default: begin n[2] = 1'b0; n[0] = 1'b0; end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/l2_plru4.sv
// rtl/l2_plru4.sv - 4-way tree pseudo-LRU: victim select and access update
module l2_plru4
    import lc3b_types::*;
(
    input  lc3b_plru    plru_in,
    input  logic [1:0]  access_way,
    output logic [1:0]  victim_way,
    output lc3b_plru    plru_next
);

    always_comb begin
        victim_way = plru_in[2] ? {1'b1, plru_in[0]} : {1'b0, plru_in[1]};
        plru_next  = plru_touch(plru_in, access_way);
    end

endmodule

// File: rtl/l2_tag_lookup.sv
// rtl/l2_tag_lookup.sv - L2 tag/valid/dirty arrays, 4-way compare, victim select
module l2_tag_lookup
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic        req_write,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_hit,
    output logic [1:0]  resp_way,
    output logic [2:0]  resp_set,
    output logic [1:0]  resp_victim_way,
    output logic [8:0]  resp_victim_tag,
    output logic        resp_victim_dirty,
    input  logic        fill_valid,
    input  logic [2:0]  fill_set,
    input  logic [1:0]  fill_way,
    input  logic [8:0]  fill_tag,
    input  logic        fill_dirty
);

    l2_state_e            state_q, state_d;
    lc3b_word             addr_q, addr_d;
    logic                 write_q, write_d;
    lc3b_l2tag            tag_q   [L2_SETS][L2_WAYS];
    lc3b_l2tag            tag_d   [L2_SETS][L2_WAYS];
    logic [L2_WAYS-1:0]   valid_q [L2_SETS];
    logic [L2_WAYS-1:0]   valid_d [L2_SETS];
    logic [L2_WAYS-1:0]   dirty_q [L2_SETS];
    logic [L2_WAYS-1:0]   dirty_d [L2_SETS];
    lc3b_plru             plru_q  [L2_SETS];
    lc3b_plru             plru_d  [L2_SETS];

    logic                 hit_q, hit_d;
    logic [1:0]           way_q, way_d;
    logic [2:0]           set_q, set_d;
    logic [1:0]           vway_q, vway_d;
    lc3b_l2tag            vtag_q, vtag_d;
    logic                 vdirty_q, vdirty_d;

    logic [2:0]           lkp_set;
    lc3b_l2tag            lkp_tag;
    logic                 lkp_hit;
    logic [1:0]           lkp_hit_way;
    logic                 inv_found;
    logic [1:0]           inv_way;
    logic [1:0]           plru_victim;
    lc3b_plru             plru_hit_next;
    logic [1:0]           victim_way;

    assign lkp_set = addr_q[L2_OFF_W +: L2_SET_W];
    assign lkp_tag = addr_q[15 -: L2_TAG_W];

    always_comb begin
        lkp_hit     = 1'b0;
        lkp_hit_way = 2'd0;
        inv_found   = 1'b0;
        inv_way     = 2'd0;
        for (int w = 0; w < L2_WAYS; w++) begin
            if (valid_q[lkp_set][w] && tag_q[lkp_set][w] == lkp_tag) begin
                lkp_hit     = 1'b1;
                lkp_hit_way = 2'(w);
            end
        end
        // Descending scan so the lowest-index invalid way is the one kept.
        for (int w = L2_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lkp_set][w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
        end
    end

    l2_plru4 u_plru (
        .plru_in    (plru_q[lkp_set]),
        .access_way (lkp_hit_way),
        .victim_way (plru_victim),
        .plru_next  (plru_hit_next)
    );

    assign victim_way = inv_found ? inv_way : plru_victim;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        plru_d   = plru_q;
        hit_d    = hit_q;
        way_d    = way_q;
        set_d    = set_q;
        vway_d   = vway_q;
        vtag_d   = vtag_q;
        vdirty_d = vdirty_q;

        case (state_q)
            L2_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    state_d = L2_LOOKUP;
                end
            end
            L2_LOOKUP: begin
                state_d  = L2_RESP;
                hit_d    = lkp_hit;
                way_d    = lkp_hit ? lkp_hit_way : 2'd0;
                set_d    = lkp_set;
                vway_d   = victim_way;
                vtag_d   = tag_q[lkp_set][victim_way];
                vdirty_d = valid_q[lkp_set][victim_way] && dirty_q[lkp_set][victim_way];
                if (lkp_hit) begin
                    plru_d[lkp_set] = plru_hit_next;
                    if (write_q) begin
                        dirty_d[lkp_set][lkp_hit_way] = 1'b1;
                    end
                end
            end
            L2_RESP: begin
                if (resp_ready) begin
                    state_d = L2_IDLE;
                end
            end
            default: state_d = L2_IDLE;
        endcase

        // Applied after the hit update so a same-set fill overrides it.
        if (fill_valid) begin
            tag_d[fill_set][fill_way]   = fill_tag;
            valid_d[fill_set][fill_way] = 1'b1;
            dirty_d[fill_set][fill_way] = fill_dirty;
            plru_d[fill_set]            = plru_touch(plru_q[fill_set], fill_way);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= L2_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            set_q    <= '0;
            vway_q   <= '0;
            vtag_q   <= '0;
            vdirty_q <= 1'b0;
            for (int s = 0; s < L2_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            hit_q    <= hit_d;
            way_q    <= way_d;
            set_q    <= set_d;
            vway_q   <= vway_d;
            vtag_q   <= vtag_d;
            vdirty_q <= vdirty_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            plru_q   <= plru_d;
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign req_ready         = (state_q == L2_IDLE);
    assign resp_valid        = (state_q == L2_RESP);
    assign resp_hit          = hit_q;
    assign resp_way          = way_q;
    assign resp_set          = set_q;
    assign resp_victim_way   = vway_q;
    assign resp_victim_tag   = vtag_q;
    assign resp_victim_dirty = vdirty_q;

endmodule

// File: tb/tb_l2_tag_lookup.sv
// tb/tb_l2_tag_lookup.sv - directed and random checks of l2_tag_lookup against a cache model
module tb_l2_tag_lookup;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_write;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [2:0]  resp_set;
    logic [1:0]  resp_victim_way;
    logic [8:0]  resp_victim_tag;
    logic        resp_victim_dirty;
    logic        fill_valid;
    logic [2:0]  fill_set;
    logic [1:0]  fill_way;
    logic [8:0]  fill_tag;
    logic        fill_dirty;

    int total = 0;
    int bad   = 0;

    l2_tag_lookup dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_write         (req_write),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_set          (resp_set),
        .resp_victim_way   (resp_victim_way),
        .resp_victim_tag   (resp_victim_tag),
        .resp_victim_dirty (resp_victim_dirty),
        .fill_valid        (fill_valid),
        .fill_set          (fill_set),
        .fill_way          (fill_way),
        .fill_tag          (fill_tag),
        .fill_dirty        (fill_dirty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference cache state
    logic [8:0] m_tag   [8][4];
    bit         m_valid [8][4];
    bit         m_dirty [8][4];
    logic [2:0] m_plru  [8];

    logic [8:0] tag_pool [5] = '{9'h024, 9'h0A4, 9'h1AB, 9'h055, 9'h100};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [2:0] f_touch(input logic [2:0] p, input int way);
        logic [2:0] n;
        n = p;
        if (way == 0)      begin n[2] = 1; n[1] = 1; end
        else if (way == 1) begin n[2] = 1; n[1] = 0; end
        else if (way == 2) begin n[2] = 0; n[0] = 1; end
        else               begin n[2] = 0; n[0] = 0; end
        return n;
    endfunction

    function automatic int f_victim(input int s);
        for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
        if (m_plru[s][2] == 1'b0) return int'(m_plru[s][1]);
        return 2 + int'(m_plru[s][0]);
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 8; s++) begin
            m_plru[s] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    task automatic m_fill(input int s, input int w, input logic [8:0] t, input bit d);
        m_tag[s][w]   = t;
        m_valid[s][w] = 1;
        m_dirty[s][w] = d;
        m_plru[s]     = f_touch(m_plru[s], w);
    endtask

    // Returns packed {hit, way, set, vway, vtag, vdirty} and applies hit side effects.
    task automatic m_lookup(input logic [15:0] addr, input bit wr, output logic [17:0] exp);
        int s, hw, vw;
        logic [8:0] t;
        bit h;
        s  = int'(addr[6:4]);
        t  = addr >> 7;
        h  = 0;
        hw = 0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                h  = 1;
                hw = w;
            end
        end
        vw  = f_victim(s);
        exp = {h, 2'(hw), 3'(s), 2'(vw), m_tag[s][vw], 1'(m_valid[s][vw] && m_dirty[s][vw])};
        if (h) begin
            m_plru[s] = f_touch(m_plru[s], hw);
            if (wr) m_dirty[s][hw] = 1;
        end
    endtask

    function automatic logic [17:0] obs_resp();
        return {resp_hit, resp_way, resp_set, resp_victim_way, resp_victim_tag, resp_victim_dirty};
    endfunction

    task automatic do_fill(input int s, input int w, input logic [8:0] t, input bit d);
        @(negedge clk);
        fill_valid = 1; fill_set = 3'(s); fill_way = 2'(w); fill_tag = t; fill_dirty = d;
        @(negedge clk);
        fill_valid = 0;
        m_fill(s, w, t, d);
    endtask

    task automatic do_req(input logic [15:0] addr, input bit wr, input bit same_fill,
                          input int fs, input int fw, input logic [8:0] ft, input bit fd,
                          input int stall, input int exp_victim);
        logic [17:0] exp;
        logic [2:0]  pre_plru;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_addr = addr; req_write = wr;
        @(negedge clk);
        req_valid = 0;
        chk("lookup_resp_valid", 32'(resp_valid), 32'd0);
        chk("lookup_req_ready", 32'(req_ready), 32'd0);
        pre_plru = m_plru[fs];
        m_lookup(addr, wr, exp);
        if (same_fill) begin
            fill_valid = 1; fill_set = 3'(fs); fill_way = 2'(fw); fill_tag = ft; fill_dirty = fd;
            m_fill(fs, fw, ft, fd);
            m_plru[fs] = f_touch(pre_plru, fw);
        end
        @(negedge clk);
        fill_valid = 0;
        chk("resp_valid_n2", 32'(resp_valid), 32'd1);
        chk("resp_fields", 32'(obs_resp()), 32'(exp));
        if (exp_victim >= 0) chk("resp_victim_way_const", 32'(resp_victim_way), 32'(exp_victim));
        for (int i = 0; i < stall; i++) begin
            fill_valid = 1; fill_set = addr[6:4]; fill_way = 2'($urandom_range(0, 3));
            fill_tag = tag_pool[$urandom_range(0, 4)]; fill_dirty = 1'($urandom_range(0, 1));
            m_fill(int'(fill_set), int'(fill_way), fill_tag, fill_dirty);
            @(negedge clk);
            fill_valid = 0;
            chk("stall_resp_held", 32'(obs_resp()), 32'(exp));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk("taken_resp_valid", 32'(resp_valid), 32'd0);
        chk("taken_req_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [15:0] mk_addr(input logic [8:0] t, input int s, input int off);
        return {t, 3'(s), 4'(off)};
    endfunction

    initial begin
        reset_n = 0; req_valid = 0; req_addr = 0; req_write = 0; resp_ready = 0;
        fill_valid = 0; fill_set = 0; fill_way = 0; fill_tag = 0; fill_dirty = 0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_fields", 32'(obs_resp()), 32'd0);

        // 1: cold miss in set 3
        do_req(16'h1230, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_set_const", 32'(resp_set), 32'd3);

        // 2: fill then write hit, then a conflicting miss
        do_fill(3, 0, 9'h024, 0);
        do_req(16'h123A, 1, 0, 0, 0, 0, 0, 0, -1);
        chk("t2_hit_const", 32'(resp_hit), 32'd1);
        do_req(16'h5230, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_dirty_kept", 32'(m_dirty[3][0]), 32'd1);

        // 3: PLRU walk in set 0
        for (int w = 0; w < 4; w++) do_fill(0, w, 9'(9'h010 + w), 0);
        for (int w = 0; w < 4; w++) do_req(mk_addr(9'(9'h010 + w), 0, w), 0, 0, 0, 0, 0, 0, 0, -1);
        do_req(mk_addr(9'h1FF, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
        do_req(mk_addr(9'h010, 0, 0), 0, 0, 0, 0, 0, 0, 0, -1);
        do_req(mk_addr(9'h1FF, 0, 0), 0, 0, 0, 0, 0, 0, 0, 2);

        // 4: dirty victim writeback in set 5
        do_fill(5, 0, 9'h1AB, 1);
        for (int w = 1; w < 4; w++) do_fill(5, w, 9'(9'h020 + w), 0);
        for (int w = 1; w < 4; w++) do_req(mk_addr(9'(9'h020 + w), 5, 0), 0, 0, 0, 0, 0, 0, 0, -1);
        do_req(mk_addr(9'h0FF, 5, 0), 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_victim_tag_const", 32'(resp_victim_tag), 32'h1AB);
        chk("t4_victim_dirty_const", 32'(resp_victim_dirty), 32'd1);

        // 5: stalled response with fills to the same set
        do_req(mk_addr(9'h022, 5, 0), 0, 0, 0, 0, 0, 0, 3, -1);

        // same-edge fill and lookup to the same set
        do_req(mk_addr(9'h023, 5, 0), 1, 1, 5, 2, 9'h077, 0, 0, -1);
        do_req(mk_addr(9'h1FE, 5, 0), 0, 0, 0, 0, 0, 0, 0, -1);

        // 6: reset during LOOKUP
        @(negedge clk);
        req_valid = 1; req_addr = 16'h123A; req_write = 0;
        @(negedge clk);
        req_valid = 0; reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        m_reset();
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        do_req(16'h123A, 0, 0, 0, 0, 0, 0, 0, -1);
        chk("t6_now_miss", 32'(resp_hit), 32'd0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            int s, w;
            s = $urandom_range(0, 7);
            w = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do_fill(s, w, tag_pool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
            end else begin
                do_req(mk_addr(tag_pool[$urandom_range(0, 4)], s, $urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 1) == 0) ? s : $urandom_range(0, 7), w,
                       tag_pool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
